multiboot_ctrl: RTL
===================

// Module: multiboot_ctrl
// PURPOSE
// Warmboot/multiboot controller that sits between the bootloader core, the user button and SB_WARMBOOT.
// It debounces the button and selects one of NUM_IMAGES configuration images:
//   - short press cycles the image; long press boots the selected image;
//   - the bootloader can boot any image through a command port.
// Boot is delayed so that USB can finish its last handshake, and a pending boot can be cancelled.
// PARAMETERS
// NUM_IMAGES         4       number of selectable images, 1..4; image index maps onto SB_WARMBOOT {S1,S0}
// DEFAULT_IMAGE      1       image selected out of reset and on an invalid command, < NUM_IMAGES
// DEBOUNCE_CYCLES    120000  consecutive stable clk cycles before the debounced level changes (10 ms at 12 MHz)
// LONG_PRESS_CYCLES  12000000 held cycles that turn a press into a boot request (1 s at 12 MHz)
// BOOT_DELAY_CYCLES  24000   cycles from arming to BOOT assertion, >= 1
// BUTTON_ACTIVE_LOW  1       1: button_raw==0 means pressed
// PORTS
// clk            in   1  system clock (12 MHz domain)
// reset          in   1  synchronous, active-low reset
// button_raw     in   1  asynchronous button pin
// boot_cmd       in   1  one-cycle boot request from the bootloader core
// cmd_image      in   2  image to boot, sampled when boot_cmd==1
// image_sel      out  2  currently selected image
// warmboot_s     out  2  to SB_WARMBOOT {S1,S0}
// warmboot_boot  out  1  to SB_WARMBOOT BOOT
// busy           out  1  1 when the FSM is in any state other than IDLE
// armed          out  1  1 in ARMED; used for LED feedback
// BEHAVIOUR
// - Reset (reset==0 at a clk edge) gives:
//   state=IDLE, image_sel=warmboot_s=DEFAULT_IMAGE, warmboot_boot=0, busy=0, armed=0, debounced level=released.
//   Reset applied mid-operation, including in BOOT, returns every output to these values on the next edge.
// - Button path:
//   - 2-FF synchroniser, then polarity normalised by BUTTON_ACTIVE_LOW.
//   - Debounce counter is cleared whenever the synchronised level equals the debounced level.
//   - The debounced level flips when the counter reaches DEBOUNCE_CYCLES-1 with the level still different.
//   - press = rising edge of the debounced level; release = falling edge.
// - FSM states IDLE, HELD, ARMED, BOOT:
//   - IDLE:
//     - boot_cmd -> ARMED, with image_sel=cmd_image, or DEFAULT_IMAGE if cmd_image>=NUM_IMAGES.
//     - else press -> HELD, hold counter cleared.
//   - HELD:
//     - boot_cmd wins over the button and acts exactly as in IDLE.
//     - release before hold count LONG_PRESS_CYCLES -> IDLE, image_sel increments modulo NUM_IMAGES
//       (NUM_IMAGES-1 wraps to 0; with NUM_IMAGES=1 it stays 0).
//     - hold counter reaches LONG_PRESS_CYCLES-1 while still pressed -> ARMED, image_sel unchanged.
//   - ARMED:
//     - delay counter loaded with BOOT_DELAY_CYCLES-1 on entry; decrements each cycle.
//     - press -> IDLE, boot cancelled, image_sel kept. A release that follows a long press does NOT cancel.
//     - boot_cmd ignored.
//     - counter==0 -> BOOT.
//   - BOOT: terminal until reset; warmboot_boot=1 held high.
// - Timing and outputs:
//   - boot_cmd sampled at edge N -> armed=1 from N+1 -> warmboot_boot=1 from N+1+BOOT_DELAY_CYCLES.
//   - warmboot_s is registered and equals image_sel.
//   - image_sel is frozen from ARMED entry, so S1/S0 are stable >= BOOT_DELAY_CYCLES cycles before BOOT rises.
//   - busy and armed are registered decodes of the state.
// - Counters are sized $clog2(param+1) bits and saturate; they never wrap.
// TESTING
// (scaled bench: DEBOUNCE=4, LONG_PRESS=20, BOOT_DELAY=3, NUM_IMAGES=3, DEFAULT_IMAGE=1)
// 1. Reset release, no stimulus -> image_sel=1, warmboot_boot=0, busy=0 for 100 cycles.
// 2. boot_cmd pulse with cmd_image=2 at edge N -> armed=1 at N+1, warmboot_s=2, warmboot_boot=1 at N+4 and held high.
// 3. Three short presses of 8 cycles each -> image_sel 1->2->0->1; never busy after release settles.
// 4. Glitch of 3 cycles on button_raw -> no press detected, state stays IDLE.
// 5. Long press of 30 cycles -> ARMED after the debounce plus 20 cycles. Second case: press again during ARMED
//    -> back to IDLE, warmboot_boot stays 0.
// 6. boot_cmd with cmd_image=3 (invalid) in HELD -> ARMED with image_sel=1. Then reset asserted while in BOOT
//    -> warmboot_boot=0 on the next edge.

Source files
------------

// File: rtl/multiboot_ctrl.sv
// Warmboot/multiboot controller: a debounced button cycles or boots images, and the bootloader can boot any image by command.
// Latency: outputs are registered decodes, one cycle after each state change. There is no backpressure; boot_cmd is a one-cycle strobe and is ignored while armed.
module multiboot_ctrl #(
  parameter int NUM_IMAGES        = 4,
  parameter int DEFAULT_IMAGE     = 1,
  parameter int DEBOUNCE_CYCLES   = 120000,
  parameter int LONG_PRESS_CYCLES = 12000000,
  parameter int BOOT_DELAY_CYCLES = 24000,
  parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button_raw,
  input  logic       boot_cmd,
  input  logic [1:0] cmd_image,
  output logic [1:0] image_sel,
  output logic [1:0] warmboot_s,
  output logic       warmboot_boot,
  output logic       busy,
  output logic       armed
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LP_W  = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int DLY_W = $clog2(BOOT_DELAY_CYCLES + 1);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LP_W-1:0]  LP_LAST  = LP_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [LP_W-1:0]  LP_MAX   = LP_W'(LONG_PRESS_CYCLES);
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(BOOT_DELAY_CYCLES - 1);
  localparam logic [1:0]       DEF_IMG  = 2'(DEFAULT_IMAGE);
  localparam logic [1:0]       IMG_LAST = 2'(NUM_IMAGES - 1);
  localparam logic [2:0]       NUM_IMG3 = 3'(NUM_IMAGES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_ARMED,
    ST_BOOT
  } state_t;

  logic            r_sync1;
  logic            r_sync2;
  logic            r_deb;
  logic            r_deb_d;
  logic [DB_W-1:0] r_db_cnt;
  logic            w_lvl;
  logic            w_press;
  logic            w_release;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LP_W-1:0]  r_hold_cnt;
  logic [LP_W-1:0]  w_hold_nxt;
  logic [DLY_W-1:0] r_dly_cnt;
  logic [DLY_W-1:0] w_dly_nxt;
  logic [1:0]       r_image_sel;
  logic [1:0]       w_image_nxt;
  logic [1:0]       w_cmd_img;
  logic [1:0]       w_img_inc;

  logic [1:0] r_warmboot_s;
  logic       r_warmboot_boot;
  logic       r_busy;
  logic       r_armed;

  // Normalised so that 1 always means pressed.
  assign w_lvl     = r_sync2 ^ BUTTON_ACTIVE_LOW;
  assign w_press   = r_deb & ~r_deb_d;
  assign w_release = ~r_deb & r_deb_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1  <= BUTTON_ACTIVE_LOW;
      r_sync2  <= BUTTON_ACTIVE_LOW;
      r_deb    <= 1'b0;
      r_deb_d  <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= button_raw;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      if (w_lvl == r_deb) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt >= DB_LAST) begin
        r_deb    <= w_lvl;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  // Out-of-range command images fall back to the default image.
  assign w_cmd_img = ({1'b0, cmd_image} < NUM_IMG3) ? cmd_image : DEF_IMG;
  assign w_img_inc = (r_image_sel >= IMG_LAST) ? 2'd0 : r_image_sel + 2'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_dly_nxt   = r_dly_cnt;
    w_image_nxt = r_image_sel;
    case (r_state)
      ST_IDLE: begin
        if (boot_cmd) begin
          w_state_nxt = ST_ARMED;
          w_image_nxt = w_cmd_img;
          w_dly_nxt   = DLY_LOAD;
        end else if (w_press) begin
          w_state_nxt = ST_HELD;
          w_hold_nxt  = '0;
        end
      end
      ST_HELD: begin
        if (boot_cmd) begin
          w_state_nxt = ST_ARMED;
          w_image_nxt = w_cmd_img;
          w_dly_nxt   = DLY_LOAD;
        end else if (w_release) begin
          w_state_nxt = ST_IDLE;
          w_image_nxt = w_img_inc;
        end else if (r_hold_cnt >= LP_LAST) begin
          w_state_nxt = ST_ARMED;
          w_dly_nxt   = DLY_LOAD;
        end else if (r_hold_cnt != LP_MAX) begin
          w_hold_nxt = r_hold_cnt + LP_W'(1);
        end
      end
      ST_ARMED: begin
        // Only a fresh press cancels; the release ending a long press is ignored here.
        if (w_press) begin
          w_state_nxt = ST_IDLE;
        end else if (r_dly_cnt == '0) begin
          w_state_nxt = ST_BOOT;
        end else begin
          w_dly_nxt = r_dly_cnt - DLY_W'(1);
        end
      end
      ST_BOOT: begin
        w_state_nxt = ST_BOOT;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_hold_cnt      <= '0;
      r_dly_cnt       <= '0;
      r_image_sel     <= DEF_IMG;
      r_warmboot_s    <= DEF_IMG;
      r_warmboot_boot <= 1'b0;
      r_busy          <= 1'b0;
      r_armed         <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_hold_cnt      <= w_hold_nxt;
      r_dly_cnt       <= w_dly_nxt;
      r_image_sel     <= w_image_nxt;
      r_warmboot_s    <= r_image_sel;
      r_warmboot_boot <= (r_state == ST_BOOT);
      r_busy          <= (r_state != ST_IDLE);
      r_armed         <= (r_state == ST_ARMED);
    end
  end

  assign image_sel     = r_image_sel;
  assign warmboot_s    = r_warmboot_s;
  assign warmboot_boot = r_warmboot_boot;
  assign busy          = r_busy;
  assign armed         = r_armed;

endmodule
